pic_seq_ctl: RTL and testbench

Parametrised frame sequencer for the SD digital picture frame. It initialises the SD and LCD SPI interface blocks, streams a configurable number of 512 B SD blocks per image into the LCD, then waits on the UART control port. It also supports wrap-around image indexing, an optional slideshow auto-advance and a handshake watchdog. It sits between the UART command decoder and the SD/LCD interface blocks, replacing the fixed 300-block, single-image sequencer.

---
 rtl/pic_seq_ctl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_pic_seq_ctl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_seq_ctl.sv
// pic_seq_ctl: frame sequencer for the SD picture frame.
// Initialises the SD and LCD SPI blocks, streams BLK_PER_FRAME SD blocks of
// the current image into the LCD, then waits for a UART command. Adds
// wrap-around image indexing, optional slideshow auto-advance and a
// begin/busy handshake watchdog.
// Ports:
//   clk_4M, rst                 clock, synchronous active-high reset
//   SD_if_*  (out)              SD op selects, begin, end_of_frame, block address
//   SD_if_busy (in)             SD interface busy
//   LCD_if_* (out)              LCD op selects, begin, end_of_frame
//   LCD_if_busy (in)            LCD interface busy
//   ctl_incr/decr/valid (in)    UART command; ctl_ready (out) accept pulse
//   img_idx (out)               current image index
//   sys_wait_led (out)          high while waiting for a command
//   err_pulse (out)             one-cycle pulse on watchdog expiry
module pic_seq_ctl #(
  parameter int unsigned BLK_PER_FRAME = 300,
  parameter int unsigned IMG_COUNT     = 16,
  parameter int unsigned BASE_BLK      = 0,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned AUTO_ADV      = 0,
  parameter int unsigned ACK_TO        = 4096
) (
  input  logic                         clk_4M,
  input  logic                         rst,
  output logic                         SD_if_init,
  output logic                         SD_if_send_rd_cmd,
  output logic                         SD_if_stream,
  output logic                         SD_if_crc,
  output logic                         SD_if_end_of_frame,
  output logic                         SD_if_begin,
  output logic [ADDR_W-1:0]            SD_if_blk_addr,
  input  logic                         SD_if_busy,
  output logic                         LCD_if_init,
  output logic                         LCD_if_send_px_cmd,
  output logic                         LCD_if_stream,
  output logic                         LCD_if_end_of_frame,
  output logic                         LCD_if_begin,
  input  logic                         LCD_if_busy,
  input  logic                         ctl_incr,
  input  logic                         ctl_decr,
  input  logic                         ctl_valid,
  output logic                         ctl_ready,
  output logic [$clog2(IMG_COUNT)-1:0] img_idx,
  output logic                         sys_wait_led,
  output logic                         err_pulse
);

  localparam int unsigned IDX_W = $clog2(IMG_COUNT);
  localparam int unsigned OFS_W = $clog2(BLK_PER_FRAME + 1);
  localparam int unsigned AA_W  = (AUTO_ADV > 1) ? $clog2(AUTO_ADV) : 1;
  localparam int unsigned WD_W  = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(IMG_COUNT - 1);
  localparam logic [OFS_W-1:0]  OFS_LAST   = OFS_W'(BLK_PER_FRAME - 1);
  localparam logic [AA_W-1:0]   AA_LAST    = AA_W'(AUTO_ADV - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(ACK_TO - 1);
  localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'(BASE_BLK);
  // Base of the last image, folded at elaboration so no multiplier is built.
  localparam logic [ADDR_W-1:0] BASE_LAST  = ADDR_W'(BASE_BLK + (IMG_COUNT - 1) * BLK_PER_FRAME);
  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(BLK_PER_FRAME);

  typedef enum logic [2:0] {
    S_INIT, S_OFS_RST, S_RD_CMD, S_STREAM, S_CRC, S_WAIT, S_IDX_MOD
  } state_t;

  state_t             r_state;
  logic               r_start;
  logic               r_sd_init, r_sd_rd, r_sd_stream, r_sd_crc, r_sd_eof, r_sd_begin;
  logic               r_lcd_init, r_lcd_px, r_lcd_stream, r_lcd_eof, r_lcd_begin;
  logic               r_ctl_ready, r_wait_led, r_err, r_dir_incr;
  logic               r_sd_busy, r_lcd_busy, r_incr, r_decr, r_valid;
  logic [IDX_W-1:0]   r_img_idx;
  logic [ADDR_W-1:0]  r_img_base, r_blk_addr;
  logic [OFS_W-1:0]   r_blk_offset;
  logic [AA_W-1:0]    r_aa_cnt;
  logic [WD_W-1:0]    r_wd_cnt;

  logic w_any_begin, w_wd_fire, w_step_done;

  assign w_any_begin = r_sd_begin | r_lcd_begin;
  assign w_wd_fire   = (ACK_TO != 0) && w_any_begin && (r_wd_cnt == WD_LAST);
  // An interface not used in this step idles with begin=0, busy=0 and counts as done.
  assign w_step_done = !r_sd_begin && !r_sd_busy && !r_lcd_begin && !r_lcd_busy;

  // Input synchroniser / single registration stage.
  always_ff @(posedge clk_4M) begin
    if (rst) begin
      r_sd_busy  <= 1'b0;
      r_lcd_busy <= 1'b0;
      r_incr     <= 1'b0;
      r_decr     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_sd_busy  <= SD_if_busy;
      r_lcd_busy <= LCD_if_busy;
      r_incr     <= ctl_incr;
      r_decr     <= ctl_decr;
      r_valid    <= ctl_valid;
    end
  end

  // Sequencer FSM with registered outputs; r_start marks the issue cycle of a step.
  always_ff @(posedge clk_4M) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_start      <= 1'b1;
      r_sd_init    <= 1'b0;
      r_sd_rd      <= 1'b0;
      r_sd_stream  <= 1'b0;
      r_sd_crc     <= 1'b0;
      r_sd_eof     <= 1'b0;
      r_sd_begin   <= 1'b0;
      r_lcd_init   <= 1'b0;
      r_lcd_px     <= 1'b0;
      r_lcd_stream <= 1'b0;
      r_lcd_eof    <= 1'b0;
      r_lcd_begin  <= 1'b0;
      r_ctl_ready  <= 1'b0;
      r_wait_led   <= 1'b0;
      r_err        <= 1'b0;
      r_dir_incr   <= 1'b0;
      r_img_idx    <= '0;
      r_img_base   <= BASE_FIRST;
      r_blk_addr   <= '0;
      r_blk_offset <= '0;
      r_aa_cnt     <= '0;
      r_wd_cnt     <= '0;
    end else begin
      r_ctl_ready <= 1'b0;
      r_err       <= 1'b0;

      if (w_any_begin) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      else             r_wd_cnt <= '0;

      if (w_wd_fire) begin
        // Abort the stuck handshake and restart from interface init.
        r_err        <= 1'b1;
        r_wd_cnt     <= '0;
        r_state      <= S_INIT;
        r_start      <= 1'b1;
        r_sd_init    <= 1'b0;
        r_sd_rd      <= 1'b0;
        r_sd_stream  <= 1'b0;
        r_sd_crc     <= 1'b0;
        r_sd_eof     <= 1'b0;
        r_sd_begin   <= 1'b0;
        r_lcd_init   <= 1'b0;
        r_lcd_px     <= 1'b0;
        r_lcd_stream <= 1'b0;
        r_lcd_eof    <= 1'b0;
        r_lcd_begin  <= 1'b0;
      end else begin
        case (r_state)
          S_INIT, S_RD_CMD, S_STREAM, S_CRC: begin
            if (r_start) begin
              r_start    <= 1'b0;
              r_sd_begin <= 1'b1;
              case (r_state)
                S_INIT: begin
                  r_sd_init   <= 1'b1;
                  r_lcd_init  <= 1'b1;
                  r_lcd_begin <= 1'b1;
                end
                S_RD_CMD: begin
                  r_sd_rd <= 1'b1;
                  if (r_blk_offset == '0) begin
                    r_lcd_px    <= 1'b1;
                    r_lcd_begin <= 1'b1;
                  end
                end
                S_STREAM: begin
                  r_sd_stream  <= 1'b1;
                  r_lcd_stream <= 1'b1;
                  r_lcd_begin  <= 1'b1;
                  r_sd_eof     <= (r_blk_offset == OFS_LAST);
                  r_lcd_eof    <= (r_blk_offset == OFS_LAST);
                end
                default: r_sd_crc <= 1'b1;
              endcase
            end else begin
              if (r_sd_begin && r_sd_busy)   r_sd_begin  <= 1'b0;
              if (r_lcd_begin && r_lcd_busy) r_lcd_begin <= 1'b0;
              if (w_step_done) begin
                r_sd_init    <= 1'b0;
                r_sd_rd      <= 1'b0;
                r_sd_stream  <= 1'b0;
                r_sd_crc     <= 1'b0;
                r_sd_eof     <= 1'b0;
                r_lcd_init   <= 1'b0;
                r_lcd_px     <= 1'b0;
                r_lcd_stream <= 1'b0;
                r_lcd_eof    <= 1'b0;
                r_start      <= 1'b1;
                case (r_state)
                  S_INIT:   r_state <= S_OFS_RST;
                  S_RD_CMD: r_state <= S_STREAM;
                  S_STREAM: r_state <= S_CRC;
                  default: begin
                    r_blk_offset <= r_blk_offset + OFS_W'(1);
                    r_blk_addr   <= r_blk_addr + ADDR_W'(1);
                    if (r_blk_offset == OFS_LAST) begin
                      r_state    <= S_WAIT;
                      r_wait_led <= 1'b1;
                      r_aa_cnt   <= '0;
                    end else begin
                      r_state <= S_RD_CMD;
                    end
                  end
                endcase
              end
            end
          end
          S_OFS_RST: begin
            r_blk_offset <= '0;
            r_blk_addr   <= r_img_base;
            r_state      <= S_RD_CMD;
            r_start      <= 1'b1;
          end
          S_WAIT: begin
            if (r_valid) begin
              r_ctl_ready <= 1'b1;
              r_wait_led  <= 1'b0;
              if (r_incr ^ r_decr) begin
                r_dir_incr <= r_incr;
                r_state    <= S_IDX_MOD;
              end else begin
                r_state <= S_OFS_RST;
              end
            end else if ((AUTO_ADV != 0) && (r_aa_cnt == AA_LAST)) begin
              r_dir_incr <= 1'b1;
              r_wait_led <= 1'b0;
              r_state    <= S_IDX_MOD;
            end else begin
              r_aa_cnt <= r_aa_cnt + AA_W'(1);
            end
          end
          S_IDX_MOD: begin
            if (r_dir_incr) begin
              if (r_img_idx == IDX_LAST) begin
                r_img_idx  <= '0;
                r_img_base <= BASE_FIRST;
              end else begin
                r_img_idx  <= r_img_idx + IDX_W'(1);
                r_img_base <= r_img_base + FRAME_STEP;
              end
            end else begin
              if (r_img_idx == '0) begin
                r_img_idx  <= IDX_LAST;
                r_img_base <= BASE_LAST;
              end else begin
                r_img_idx  <= r_img_idx - IDX_W'(1);
                r_img_base <= r_img_base - FRAME_STEP;
              end
            end
            r_state <= S_OFS_RST;
          end
          default: begin
            r_state <= S_INIT;
            r_start <= 1'b1;
          end
        endcase
      end
    end
  end

  assign SD_if_init          = r_sd_init;
  assign SD_if_send_rd_cmd   = r_sd_rd;
  assign SD_if_stream        = r_sd_stream;
  assign SD_if_crc           = r_sd_crc;
  assign SD_if_end_of_frame  = r_sd_eof;
  assign SD_if_begin         = r_sd_begin;
  assign SD_if_blk_addr      = r_blk_addr;
  assign LCD_if_init         = r_lcd_init;
  assign LCD_if_send_px_cmd  = r_lcd_px;
  assign LCD_if_stream       = r_lcd_stream;
  assign LCD_if_end_of_frame = r_lcd_eof;
  assign LCD_if_begin        = r_lcd_begin;
  assign ctl_ready           = r_ctl_ready;
  assign img_idx             = r_img_idx;
  assign sys_wait_led        = r_wait_led;
  assign err_pulse           = r_err;

endmodule

// File: tb/tb_pic_seq_ctl.sv
// tb_pic_seq_ctl: scoreboard bench for pic_seq_ctl with BLK_PER_FRAME=3,
// IMG_COUNT=4, AUTO_ADV=100, ACK_TO=50 and 5-cycle busy BFMs.
module tb_pic_seq_ctl;

  logic        clk_4M, rst;
  logic        SD_if_init, SD_if_send_rd_cmd, SD_if_stream, SD_if_crc;
  logic        SD_if_end_of_frame, SD_if_begin, SD_if_busy;
  logic [31:0] SD_if_blk_addr;
  logic        LCD_if_init, LCD_if_send_px_cmd, LCD_if_stream;
  logic        LCD_if_end_of_frame, LCD_if_begin, LCD_if_busy;
  logic        ctl_incr, ctl_decr, ctl_valid, ctl_ready;
  logic [1:0]  img_idx;
  logic        sys_wait_led, err_pulse;

  pic_seq_ctl #(
    .BLK_PER_FRAME(3), .IMG_COUNT(4), .BASE_BLK(0), .ADDR_W(32),
    .AUTO_ADV(100), .ACK_TO(50)
  ) dut (
    .clk_4M(clk_4M), .rst(rst),
    .SD_if_init(SD_if_init), .SD_if_send_rd_cmd(SD_if_send_rd_cmd),
    .SD_if_stream(SD_if_stream), .SD_if_crc(SD_if_crc),
    .SD_if_end_of_frame(SD_if_end_of_frame), .SD_if_begin(SD_if_begin),
    .SD_if_blk_addr(SD_if_blk_addr), .SD_if_busy(SD_if_busy),
    .LCD_if_init(LCD_if_init), .LCD_if_send_px_cmd(LCD_if_send_px_cmd),
    .LCD_if_stream(LCD_if_stream), .LCD_if_end_of_frame(LCD_if_end_of_frame),
    .LCD_if_begin(LCD_if_begin), .LCD_if_busy(LCD_if_busy),
    .ctl_incr(ctl_incr), .ctl_decr(ctl_decr), .ctl_valid(ctl_valid),
    .ctl_ready(ctl_ready), .img_idx(img_idx),
    .sys_wait_led(sys_wait_led), .err_pulse(err_pulse)
  );

  initial clk_4M = 1'b0;
  always #5 clk_4M = ~clk_4M;

  // Busy BFMs: busy rises the edge after begin is seen and stays high 5 cycles.
  logic     sd_bfm_en;
  bit [3:0] sd_cnt, lcd_cnt;
  always @(posedge clk_4M) begin
    if (rst) begin
      SD_if_busy <= 1'b0; sd_cnt <= 4'd0;
    end else if (sd_cnt != 4'd0) begin
      sd_cnt <= sd_cnt - 4'd1;
      if (sd_cnt == 4'd1) SD_if_busy <= 1'b0;
    end else if (SD_if_begin && sd_bfm_en) begin
      SD_if_busy <= 1'b1; sd_cnt <= 4'd5;
    end
  end
  always @(posedge clk_4M) begin
    if (rst) begin
      LCD_if_busy <= 1'b0; lcd_cnt <= 4'd0;
    end else if (lcd_cnt != 4'd0) begin
      lcd_cnt <= lcd_cnt - 4'd1;
      if (lcd_cnt == 4'd1) LCD_if_busy <= 1'b0;
    end else if (LCD_if_begin) begin
      LCD_if_busy <= 1'b1; lcd_cnt <= 4'd5;
    end
  end

  // Event kinds: 1 op issue, 2 ready width, 3 watchdog, 4 WAIT entry idx,
  // 6 auto-advance WAIT length, 7 post-reset outputs.
  logic [47:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [3:0] SD_INIT = 4'b1000, SD_RD = 4'b0100, SD_ST = 4'b0010, SD_CRC = 4'b0001;
  localparam logic [2:0] L_INIT = 3'b100, L_PX = 3'b010, L_ST = 3'b001, L_NONE = 3'b000;

  function automatic logic [47:0] mk(input logic [3:0] k, input logic [43:0] p);
    return {k, p};
  endfunction

  function automatic string kname(input logic [3:0] k);
    case (k)
      4'd1:    return "op_issue";
      4'd2:    return "ready_width";
      4'd3:    return "watchdog";
      4'd4:    return "wait_entry_idx";
      4'd6:    return "auto_adv_len";
      4'd7:    return "reset_outputs";
      default: return "unknown";
    endcase
  endfunction

  task automatic check_ev(input logic [47:0] got);
    logic [47:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event got=%h required=none", kname(got[47:44]), got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s got=%h required=%h", kname(e[47:44]), got, e);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  initial begin
    logic prev_rst, prev_sd_begin, prev_led, rst_pending, cleared, anyout;
    int rdy_w, led_w, beg_w;
    prev_rst = 1'b0; prev_sd_begin = 1'b0; prev_led = 1'b0; rst_pending = 1'b0;
    rdy_w = 0; led_w = 0; beg_w = 0;
    forever begin
      @(negedge clk_4M);
      if (rst_pending) begin
        anyout = SD_if_init | SD_if_send_rd_cmd | SD_if_stream | SD_if_crc |
                 SD_if_end_of_frame | SD_if_begin | (|SD_if_blk_addr) |
                 LCD_if_init | LCD_if_send_px_cmd | LCD_if_stream |
                 LCD_if_end_of_frame | LCD_if_begin | ctl_ready |
                 sys_wait_led | err_pulse;
        check_ev(mk(4'd7, {41'd0, img_idx, anyout}));
        rst_pending = 1'b0;
      end
      if (rst && !prev_rst) rst_pending = 1'b1;
      if (SD_if_begin && !prev_sd_begin)
        check_ev(mk(4'd1, {2'b00,
          SD_if_init, SD_if_send_rd_cmd, SD_if_stream, SD_if_crc,
          LCD_if_init, LCD_if_send_px_cmd, LCD_if_stream, LCD_if_begin,
          SD_if_end_of_frame, LCD_if_end_of_frame,
          (SD_if_send_rd_cmd ? SD_if_blk_addr : 32'd0)}));
      if (ctl_ready) rdy_w++;
      else if (rdy_w != 0) begin
        check_ev(mk(4'd2, {28'd0, 16'(rdy_w)}));
        rdy_w = 0;
      end
      if (err_pulse) begin
        cleared = !(SD_if_init | SD_if_send_rd_cmd | SD_if_stream | SD_if_crc |
                    SD_if_end_of_frame | SD_if_begin | LCD_if_init |
                    LCD_if_send_px_cmd | LCD_if_stream | LCD_if_end_of_frame |
                    LCD_if_begin);
        check_ev(mk(4'd3, {25'd0, 16'(beg_w), cleared, img_idx}));
      end
      if (SD_if_begin) beg_w++; else beg_w = 0;
      if (sys_wait_led && !prev_led) check_ev(mk(4'd4, {42'd0, img_idx}));
      if (sys_wait_led) led_w++;
      else if (prev_led) begin
        if (!ctl_ready) check_ev(mk(4'd6, {28'd0, 16'(led_w)}));
        led_w = 0;
      end
      prev_rst = rst; prev_sd_begin = SD_if_begin; prev_led = sys_wait_led;
    end
  end

  task automatic push_op(input logic [3:0] sd, input logic [2:0] lcd,
                         input logic eof, input logic [31:0] addr);
    exp_q.push_back(mk(4'd1, {2'b00, sd, lcd, (lcd != 3'b000), eof, eof, addr}));
  endtask

  task automatic push_block(input int base, input int b);
    push_op(SD_RD, (b == 0) ? L_PX : L_NONE, 1'b0, 32'(base + b));
    push_op(SD_ST, L_ST, (b == 2), 32'd0);
    push_op(SD_CRC, L_NONE, 1'b0, 32'd0);
  endtask

  task automatic push_frame(input int base, input logic [1:0] idx);
    for (int b = 0; b < 3; b++) push_block(base, b);
    exp_q.push_back(mk(4'd4, {42'd0, idx}));
  endtask

  task automatic tick();
    @(posedge clk_4M);
    #2;
  endtask

  task automatic pulse(input logic inc, input logic dec);
    ctl_incr = inc; ctl_decr = dec; ctl_valid = 1'b1;
    tick();
    ctl_incr = 1'b0; ctl_decr = 1'b0; ctl_valid = 1'b0;
  endtask

  // Waits for sys_wait_led to go low (if high) and then high again.
  task automatic wait_frame_done(input string name);
    bit saw_low, done;
    saw_low = !sys_wait_led; done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (!sys_wait_led) saw_low = 1'b1;
      else if (saw_low) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got=no_wait required=wait_led_high", name);
    end
  endtask

  initial begin
    bit hit;
    rst = 1'b1; ctl_incr = 1'b0; ctl_decr = 1'b0; ctl_valid = 1'b0; sd_bfm_en = 1'b1;

    // Reset, init and first frame of image 0.
    exp_q.push_back(mk(4'd7, 44'd0));
    push_op(SD_INIT, L_INIT, 1'b0, 32'd0);
    push_frame(0, 2'd0);
    repeat (3) @(posedge clk_4M);
    #2 rst = 1'b0;
    wait_frame_done("frame0");

    // decr from 0 wraps to image 3 at block 9.
    exp_q.push_back(mk(4'd2, 44'd1));
    push_frame(9, 2'd3);
    repeat (3) tick();
    pulse(1'b0, 1'b1);
    wait_frame_done("decr_wrap");

    // incr from 3 wraps to image 0.
    exp_q.push_back(mk(4'd2, 44'd1));
    push_frame(0, 2'd0);
    repeat (3) tick();
    pulse(1'b1, 1'b0);
    wait_frame_done("incr_wrap");

    // incr+decr together redraws the same image.
    exp_q.push_back(mk(4'd2, 44'd1));
    push_frame(0, 2'd0);
    repeat (3) tick();
    pulse(1'b1, 1'b1);
    wait_frame_done("redraw");

    // No command: auto-advance after 100 WAIT cycles.
    exp_q.push_back(mk(4'd6, 44'd100));
    push_frame(3, 2'd1);
    wait_frame_done("auto_adv");

    // SD never acknowledges: watchdog fires after 50 begin cycles, idx kept.
    exp_q.push_back(mk(4'd2, 44'd1));
    push_op(SD_RD, L_PX, 1'b0, 32'd6);
    exp_q.push_back(mk(4'd3, {25'd0, 16'd50, 1'b1, 2'd2}));
    push_op(SD_INIT, L_INIT, 1'b0, 32'd0);
    push_frame(6, 2'd2);
    repeat (3) tick();
    sd_bfm_en = 1'b0;
    pulse(1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick();
      if (err_pulse) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL err_pulse timeout got=0 required=1");
    end
    sd_bfm_en = 1'b1;
    wait_frame_done("after_watchdog");

    // Reset during STREAM of block 1 of image 3.
    exp_q.push_back(mk(4'd2, 44'd1));
    push_block(9, 0);
    push_op(SD_RD, L_NONE, 1'b0, 32'd10);
    push_op(SD_ST, L_ST, 1'b0, 32'd0);
    exp_q.push_back(mk(4'd7, 44'd0));
    push_op(SD_INIT, L_INIT, 1'b0, 32'd0);
    push_frame(0, 2'd0);
    repeat (3) tick();
    pulse(1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      tick();
      if (SD_if_stream && SD_if_blk_addr == 32'd10) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL stream_blk1 timeout got=0 required=1");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_frame_done("after_reset");

    repeat (20) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
